// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the byte-RAM read port and the instruction
// valid/ready handoff of the fetch engine. The fetch unit is the master;
// the RAM model and the decode stage together form the slave side.
interface fetch_unit_if #(
  parameter int ADDR_W      = 16,
  parameter int INSTR_BYTES = 4
);
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [7:0]               mem_rdata;
  logic                     instr_valid;
  logic                     instr_ready;
  logic [8*INSTR_BYTES-1:0] instr;
  logic [ADDR_W-1:0]        instr_pc;

  modport master (
    output mem_we, mem_addr, instr_valid, instr, instr_pc,
    input  mem_rdata, instr_ready
  );

  modport slave (
    input  mem_we, mem_addr, instr_valid, instr, instr_pc,
    output mem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: reads INSTR_BYTES consecutive bytes from a byte-wide registered
// RAM starting at pc, assembles them little-endian and offers the word to
// decode over valid/ready. Supports RAM latency 1..4, back-to-back fetch,
// flush and address wrap-around.
// Optional macro FETCH_ALIGN_CHECK_EN: adds the misaligned output; a start
// whose pc is not a multiple of INSTR_BYTES completes at once with instr=0.
module fetch_unit #(
  parameter int ADDR_W      = 16,
  parameter int INSTR_BYTES = 4,
  parameter int RAM_LATENCY = 1
) (
  input  logic              ram_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              busy,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic              misaligned,
`endif
  fetch_unit_if.master      bus
);

  localparam int IDX_W  = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
  localparam int CNT_W  = $clog2(RAM_LATENCY + 1);
  localparam int DATA_W = 8 * INSTR_BYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INSTR_BYTES - 1);
  localparam logic [CNT_W-1:0] LAT_CNT  = CNT_W'(RAM_LATENCY);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shadow, shadow_next, instr_q;
  logic              instr_valid_q;
  logic              accept, sample, last_byte, reject;

  assign accept    = start && !flush &&
                     (state == IDLE || (state == DONE && bus.instr_ready));
  assign sample    = (state == FETCH) && (cnt == LAT_CNT);
  assign last_byte = sample && (idx == LAST_IDX);

`ifdef FETCH_ALIGN_CHECK_EN
  assign reject = (pc % ADDR_W'(INSTR_BYTES)) != '0;
`else
  assign reject = 1'b0;
`endif

  assign bus.mem_we      = 1'b0;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

  // Shadow word with the byte currently on the RAM output merged in.
  always_comb begin
    shadow_next = shadow;
    shadow_next[{idx, 3'b000} +: 8] = bus.mem_rdata;
  end

  // State register.
  always_ff @(posedge ram_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decode; flush wins over everything but reset.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = reject ? DONE : FETCH;
        FETCH:   if (last_byte) state_next = DONE;
        DONE:    if (bus.instr_ready)
                   state_next = accept ? (reject ? DONE : FETCH) : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Address sequencing, latency counting, byte capture and output handoff.
  always_ff @(posedge ram_clk or negedge rst) begin
    if (!rst) begin
      busy          <= 1'b0;
      base          <= '0;
      mem_addr_q    <= '0;
      instr_pc_q    <= '0;
      idx           <= '0;
      cnt           <= '0;
      shadow        <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      misaligned    <= 1'b0;
`endif
    end else if (flush) begin
      busy          <= 1'b0;
      instr_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      misaligned    <= 1'b0;
`endif
    end else begin
      if (state == DONE && bus.instr_ready) begin
        instr_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        misaligned    <= 1'b0;
`endif
      end
      if (accept) begin
        if (reject) begin
          instr_valid_q <= 1'b1;
          instr_q       <= '0;
          instr_pc_q    <= pc;
          busy          <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
          misaligned    <= 1'b1;
`endif
        end else begin
          base       <= pc;
          mem_addr_q <= pc;
          idx        <= '0;
          cnt        <= '0;
          busy       <= 1'b1;
        end
      end
      if (state == FETCH) begin
        if (sample) begin
          shadow     <= shadow_next;
          mem_addr_q <= base + ADDR_W'(idx) + ADDR_W'(1);
          idx        <= idx + IDX_W'(1);
          cnt        <= '0;
          if (last_byte) begin
            instr_q       <= shadow_next;
            instr_pc_q    <= base;
            instr_valid_q <= 1'b1;
            busy          <= 1'b0;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch_unit (default latency) and a second instance
// with RAM_LATENCY=2 from a shared random byte RAM. Expected instruction
// words and completion times come from the byte-sequence rule
// word = ram[pc+0..N-1] (mod 2^ADDR_W), ready after N*(latency+1) edges.
module tb_fetch_unit;

  localparam int ADDR_W = 16;
  localparam int N      = 4;
  localparam int LAT    = 1;
  localparam int LAT2   = 2;

  logic              ram_clk = 1'b0;
  logic              rst     = 1'b0;
  logic              start   = 1'b0;
  logic              flush   = 1'b0;
  logic [ADDR_W-1:0] pc      = '0;
  logic              busy;
  logic              start2  = 1'b0;
  logic              flush2  = 1'b0;
  logic [ADDR_W-1:0] pc2     = '0;
  logic              busy2;
`ifdef FETCH_ALIGN_CHECK_EN
  logic              misaligned;
  logic              misaligned2;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] ram [0:65535];
  logic [7:0] pipe1;
  logic [7:0] pipe2 [2];

  fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_BYTES(N)) bus ();
  fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_BYTES(N)) bus2 ();

  fetch_unit #(.ADDR_W(ADDR_W), .INSTR_BYTES(N), .RAM_LATENCY(LAT)) dut (
    .ram_clk    (ram_clk),
    .rst        (rst),
    .start      (start),
    .pc         (pc),
    .flush      (flush),
    .busy       (busy),
`ifdef FETCH_ALIGN_CHECK_EN
    .misaligned (misaligned),
`endif
    .bus        (bus)
  );

  fetch_unit #(.ADDR_W(ADDR_W), .INSTR_BYTES(N), .RAM_LATENCY(LAT2)) dut2 (
    .ram_clk    (ram_clk),
    .rst        (rst),
    .start      (start2),
    .pc         (pc2),
    .flush      (flush2),
    .busy       (busy2),
`ifdef FETCH_ALIGN_CHECK_EN
    .misaligned (misaligned2),
`endif
    .bus        (bus2)
  );

  always #5 ram_clk = ~ram_clk;

  // Edge counter used to time completion relative to the accept edge.
  always @(posedge ram_clk) cyc <= cyc + 1;

  // Registered RAMs: one and two stages between address and data_out.
  always @(posedge ram_clk) begin
    pipe1    <= ram[bus.mem_addr];
    pipe2[0] <= ram[bus2.mem_addr];
    pipe2[1] <= pipe2[0];
  end
  assign bus.mem_rdata  = pipe1;
  assign bus2.mem_rdata = pipe2[1];

  // Compares one observed value against the bench-computed expectation.
  task automatic check_output(input string tag, input logic [63:0] got,
                              input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge ram_clk);
    #1;
  endtask

  function automatic logic [63:0] exp_instr(input logic [ADDR_W-1:0] p);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[8*i +: 8] = ram[ADDR_W'(int'(p) + i)];
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] p);
`ifdef FETCH_ALIGN_CHECK_EN
    return p - (p % ADDR_W'(N));
`else
    return p;
`endif
  endfunction

  // Starts a fetch from IDLE; e0 is the edge count of the accept edge.
  task automatic apply_stimulus(input logic [ADDR_W-1:0] p, output int e0);
    start = 1'b1;
    pc    = p;
    step();
    start = 1'b0;
    pc    = 16'($urandom);
    e0    = cyc;
    check_output("busy_start", 64'(busy), 64'(1'b1));
    check_output("addr_start", 64'(bus.mem_addr), 64'(p));
  endtask

  // Waits (bounded) for completion and checks timing, addresses and data.
  task automatic wait_done(input logic [ADDR_W-1:0] p, input int e0);
    int n;
    bit addr_err, busy_err;
    n = 0; addr_err = 0; busy_err = 0;
    while (!bus.instr_valid && n < 100) begin
      if (bus.mem_addr !== ADDR_W'(int'(p) + (cyc - e0) / (LAT + 1))) addr_err = 1;
      if (busy !== 1'b1) busy_err = 1;
      start = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    start = 1'b0;
    check_output("done_latency", 64'(cyc - e0), 64'(N * (LAT + 1)));
    check_output("addr_seq", 64'(addr_err), 64'(0));
    check_output("busy_fetch", 64'(busy_err), 64'(0));
    check_output("instr", 64'(bus.instr), exp_instr(p));
    check_output("instr_pc", 64'(bus.instr_pc), 64'(p));
    check_output("busy_done", 64'(busy), 64'(0));
  endtask

  // Holds the result for 'stall' cycles, then retires it (optionally with
  // a back-to-back start at nextp, whose accept edge is returned in e0).
  task automatic retire(input int stall, input bit b2b,
                        input logic [ADDR_W-1:0] nextp, output int e0);
    logic [63:0] held;
    held = 64'(bus.instr);
    e0   = cyc;
    for (int s = 0; s < stall; s++) begin
      bus.instr_ready = 1'b0;
      start = 1'($urandom_range(0, 1));
      pc    = 16'($urandom);
      step();
      check_output("hold_valid", 64'(bus.instr_valid), 64'(1'b1));
      check_output("hold_instr", 64'(bus.instr), held);
      check_output("hold_busy", 64'(busy), 64'(0));
    end
    bus.instr_ready = 1'b1;
    if (b2b) begin
      start = 1'b1;
      pc    = nextp;
      step();
      start = 1'b0;
      e0    = cyc;
      check_output("b2b_valid", 64'(bus.instr_valid), 64'(0));
      check_output("b2b_busy", 64'(busy), 64'(1'b1));
    end else begin
      start = 1'b0;
      step();
      check_output("retire_valid", 64'(bus.instr_valid), 64'(0));
      check_output("retire_busy", 64'(busy), 64'(0));
    end
    bus.instr_ready = 1'($urandom_range(0, 1));
  endtask

  // Flushes an in-flight fetch at a random point, with a start alongside.
  task automatic flush_mid();
    logic [ADDR_W-1:0] a;
    bit seen;
    repeat ($urandom_range(1, N * (LAT + 1) - 1)) step();
    a     = bus.mem_addr;
    flush = 1'b1;
    start = 1'b1;
    pc    = 16'($urandom);
    step();
    flush = 1'b0;
    start = 1'b0;
    check_output("flush_busy", 64'(busy), 64'(0));
    check_output("flush_valid", 64'(bus.instr_valid), 64'(0));
    check_output("flush_addr", 64'(bus.mem_addr), 64'(a));
    seen = 0;
    repeat (N * (LAT + 1) + 2) begin
      step();
      if (bus.instr_valid || busy) seen = 1;
    end
    check_output("flush_quiet", 64'(seen), 64'(0));
  endtask

  initial begin : main
    int e0, n;
    bit err;
    logic [ADDR_W-1:0] p, q;

    bus.instr_ready  = 1'b0;
    bus2.instr_ready = 1'b0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
    ram[4] = 8'h55; ram[5] = 8'h66; ram[6] = 8'h77; ram[7] = 8'h88;

    // Reset values.
    repeat (3) step();
    check_output("rst_busy", 64'(busy), 64'(0));
    check_output("rst_valid", 64'(bus.instr_valid), 64'(0));
    check_output("rst_instr", 64'(bus.instr), 64'(0));
    check_output("rst_instr_pc", 64'(bus.instr_pc), 64'(0));
    check_output("rst_addr", 64'(bus.mem_addr), 64'(0));
    check_output("rst_we", 64'(bus.mem_we), 64'(0));
    check_output("rst_busy2", 64'(busy2), 64'(0));
`ifdef FETCH_ALIGN_CHECK_EN
    check_output("rst_misaligned", 64'(misaligned), 64'(0));
`endif
    rst = 1'b1;
    step();
    step();

    // Basic fetch, then stall 5 cycles and back-to-back fetch at pc=4.
    bus.instr_ready = 1'b1;
    apply_stimulus(16'h0000, e0);
    wait_done(16'h0000, e0);
    check_output("basic_word", 64'(bus.instr), 64'h44332211);
    retire(5, 1'b1, 16'h0004, e0);
    wait_done(16'h0004, e0);
    check_output("b2b_word", 64'(bus.instr), 64'h88776655);
    retire(0, 1'b0, '0, e0);

    // Wrap-around at the top of the address space.
    p = align(16'hFFFE);
    apply_stimulus(p, e0);
    wait_done(p, e0);
    retire(1, 1'b0, '0, e0);

    // Flush mid-fetch, then flush of a held instruction.
    apply_stimulus(16'h0100, e0);
    flush_mid();
    apply_stimulus(16'h0200, e0);
    wait_done(16'h0200, e0);
    bus.instr_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_output("flush_done_valid", 64'(bus.instr_valid), 64'(0));
    step();
    check_output("flush_done_idle", 64'(busy), 64'(0));

    // Second instance: latency 2 with wrap, each address held 3 cycles.
    p      = align(16'hFFFE);
    start2 = 1'b1;
    pc2    = p;
    step();
    start2 = 1'b0;
    e0 = cyc; n = 0; err = 0;
    while (!bus2.instr_valid && n < 100) begin
      if (bus2.mem_addr !== ADDR_W'(int'(p) + (cyc - e0) / (LAT2 + 1))) err = 1;
      step();
      n++;
    end
    check_output("lat2_latency", 64'(cyc - e0), 64'(N * (LAT2 + 1)));
    check_output("lat2_addr_seq", 64'(err), 64'(0));
    check_output("lat2_instr", 64'(bus2.instr), exp_instr(p));
    check_output("lat2_instr_pc", 64'(bus2.instr_pc), 64'(p));
    check_output("lat2_busy", 64'(busy2), 64'(0));
    bus2.instr_ready = 1'b1;
    step();
    check_output("lat2_retire", 64'(bus2.instr_valid), 64'(0));
    bus2.instr_ready = 1'b0;

    // Asynchronous reset in the middle of a fetch, then a clean fetch.
    bus.instr_ready = 1'b0;
    apply_stimulus(16'h0010, e0);
    repeat (4) step();
    #2 rst = 1'b0;
    #1;
    check_output("arst_busy", 64'(busy), 64'(0));
    check_output("arst_addr", 64'(bus.mem_addr), 64'(0));
    check_output("arst_instr", 64'(bus.instr), 64'(0));
    check_output("arst_instr_pc", 64'(bus.instr_pc), 64'(0));
    step();
    rst = 1'b1;
    step();
    apply_stimulus(16'h0020, e0);
    wait_done(16'h0020, e0);
    retire(0, 1'b0, '0, e0);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned start completes immediately with a zero word.
    bus.instr_ready = 1'b0;
    start = 1'b1;
    pc    = 16'h0002;
    step();
    start = 1'b0;
    check_output("mis_valid", 64'(bus.instr_valid), 64'(1'b1));
    check_output("mis_flag", 64'(misaligned), 64'(1'b1));
    check_output("mis_instr", 64'(bus.instr), 64'(0));
    check_output("mis_instr_pc", 64'(bus.instr_pc), 64'h0002);
    check_output("mis_busy", 64'(busy), 64'(0));
    bus.instr_ready = 1'b1;
    step();
    check_output("mis_clear_valid", 64'(bus.instr_valid), 64'(0));
    check_output("mis_clear_flag", 64'(misaligned), 64'(0));
    apply_stimulus(16'h0004, e0);
    wait_done(16'h0004, e0);
    check_output("aligned_flag", 64'(misaligned), 64'(0));
    retire(0, 1'b0, '0, e0);
`endif

    // Randomized fetches: stalls, back-to-back pairs, flushes, wraps.
    for (int it = 0; it < 30; it++) begin
      p = align(16'($urandom));
      if (it % 4 == 0) p = align(16'hFFFC + 16'($urandom_range(0, 3)));
      bus.instr_ready = 1'($urandom_range(0, 1));
      apply_stimulus(p, e0);
      case ($urandom_range(0, 5))
        0: flush_mid();
        1, 2, 3: begin
          wait_done(p, e0);
          retire($urandom_range(0, 4), 1'b0, '0, e0);
        end
        default: begin
          wait_done(p, e0);
          q = align(16'($urandom));
          retire($urandom_range(0, 4), 1'b1, q, e0);
          wait_done(q, e0);
          retire($urandom_range(0, 4), 1'b0, '0, e0);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
